ahb_sram_ctrl: RTL and testbench

//  AHB-lite slave that turns bus cycles into accesses on a single-port synchronous SRAM
//  (1-cycle read latency, per-byte write enables). Sits directly downstream of the ahb_sim

---
 rtl/ahb_sram_ctrl.sv | 157 +++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
// AHB-lite slave bridging bus transfers onto a single-port synchronous SRAM.
// Zero-wait by default; one stall cycle on a write data phase followed by a read address phase.
module ahb_sram_ctrl #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ahb_addr,
  input  logic [1:0]        ahb_trans,
  input  logic              ahb_write,
  input  logic [31:0]       ahb_wdata,
  input  logic [2:0]        ahb_size,
  output logic [31:0]       ahb_rdata,
  output logic              ahb_ready,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              size_err
);

  localparam int unsigned WS_W = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DP_RD    = 2'd1,
    S_DP_WR    = 2'd2,
    S_WR_STALL = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WS_W-1:0]   r_ws_cnt;
  logic [ADDR_W-1:0] r_dp_addr;
  logic [3:0]        r_dp_be;
  logic [31:0]       r_rdata_q;
  logic              r_rd_first;
  logic              r_size_err;

  logic              w_accept;
  logic              w_last;
  logic              w_clash;
  logic [3:0]        w_be;
  logic              w_bad;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_unused_addr;

  assign w_word_addr   = ahb_addr[ADDR_W+1:2];
  assign w_unused_addr = ^ahb_addr[31:ADDR_W+2];
  assign w_last        = (r_ws_cnt == '0);
  assign sram_wdata    = ahb_wdata;
  assign size_err      = r_size_err;

  // Little-endian lane decode; unsupported sizes act as word, misalignment aligns down.
  always_comb begin
    w_be  = 4'b1111;
    w_bad = 1'b0;
    case (ahb_size)
      3'b000:  w_be = 4'b0001 << ahb_addr[1:0];
      3'b001:  begin
        w_be  = ahb_addr[1] ? 4'b1100 : 4'b0011;
        w_bad = ahb_addr[0];
      end
      3'b010:  w_bad = |ahb_addr[1:0];
      default: w_bad = 1'b1;
    endcase
  end

  // Next state and bus/SRAM strobes.
  always_comb begin
    w_next    = r_state;
    ahb_ready = 1'b1;
    ahb_rdata = 32'h0;
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_be   = 4'b0000;
    sram_addr = w_word_addr;
    w_clash   = 1'b0;
    w_accept  = 1'b0;

    case (r_state)
      S_DP_RD: begin
        ahb_ready = w_last;
        ahb_rdata = r_rd_first ? sram_rdata : r_rdata_q;
      end
      S_DP_WR: begin
        if (w_last) begin
          sram_cs   = 1'b1;
          sram_we   = 1'b1;
          sram_be   = r_dp_be;
          sram_addr = r_dp_addr;
          w_clash   = ahb_trans[1] & ~ahb_write;
          ahb_ready = ~w_clash;
        end else begin
          ahb_ready = 1'b0;
        end
      end
      default: ;
    endcase

    w_accept = ahb_ready & ahb_trans[1] & ~reset;

    // A read is launched in its address phase so data lands in data-phase cycle 1.
    if (w_accept && !ahb_write) begin
      sram_cs   = 1'b1;
      sram_we   = 1'b0;
      sram_addr = w_word_addr;
    end

    if (w_clash) begin
      w_next = S_WR_STALL;
    end else if (w_accept) begin
      w_next = ahb_write ? S_DP_WR : S_DP_RD;
    end else if (ahb_ready) begin
      w_next = S_IDLE;
    end

    if (reset) begin
      sram_cs = 1'b0;
      sram_we = 1'b0;
      sram_be = 4'b0000;
    end
  end

  // State, data-phase capture, wait counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ws_cnt   <= '0;
      r_dp_addr  <= '0;
      r_dp_be    <= 4'b0000;
      r_rdata_q  <= 32'h0;
      r_rd_first <= 1'b0;
      r_size_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_first <= w_accept & ~ahb_write;
      if (r_rd_first) begin
        r_rdata_q <= sram_rdata;
      end
      if (w_accept) begin
        r_ws_cnt  <= WS_W'(WAIT_STATES);
        r_dp_addr <= w_word_addr;
        r_dp_be   <= w_be;
        if (w_bad) begin
          r_size_err <= 1'b1;
        end
      end else if (r_ws_cnt != '0) begin
        r_ws_cnt <= r_ws_cnt - WS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Self-checking bench for ahb_sram_ctrl: two instances (0 and 2 wait states), each with a
// behavioural SRAM, checked against a byte-addressed memory model and transfer-timing rules.
module tb_ahb_sram_ctrl;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } tx_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_clr;

  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic [2:0]  hsize  [2];
  logic [31:0] rdata  [2];
  logic        ready  [2];
  logic        cs     [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [11:0] saddr  [2];
  logic [31:0] swdata [2];
  logic [31:0] srdata [2];
  logic        serr   [2];

  logic [31:0] smem [2][4096];
  logic [7:0]  mdl  [2][16384];
  int          cs_cnt [2];
  int          we_cnt [2];
  logic [3:0]  last_be [2];
  logic [11:0] last_waddr [2];

  tx_t         txq[$];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ahb_sram_ctrl #(.ADDR_W(12), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .ahb_addr(haddr[0]), .ahb_trans(htrans[0]),
    .ahb_write(hwrite[0]), .ahb_wdata(hwdata[0]), .ahb_size(hsize[0]),
    .ahb_rdata(rdata[0]), .ahb_ready(ready[0]), .sram_cs(cs[0]), .sram_we(we[0]),
    .sram_be(be[0]), .sram_addr(saddr[0]), .sram_wdata(swdata[0]),
    .sram_rdata(srdata[0]), .size_err(serr[0])
  );

  ahb_sram_ctrl #(.ADDR_W(12), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .reset(reset), .ahb_addr(haddr[1]), .ahb_trans(htrans[1]),
    .ahb_write(hwrite[1]), .ahb_wdata(hwdata[1]), .ahb_size(hsize[1]),
    .ahb_rdata(rdata[1]), .ahb_ready(ready[1]), .sram_cs(cs[1]), .sram_we(we[1]),
    .sram_be(be[1]), .sram_addr(saddr[1]), .sram_wdata(swdata[1]),
    .sram_rdata(srdata[1]), .size_err(serr[1])
  );

  // Behavioural SRAMs plus strobe monitors.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int d = 0; d < 2; d++) begin
        for (int w = 0; w < 4096; w++) smem[d][w] <= 32'h0;
        cs_cnt[d] <= 0;
        we_cnt[d] <= 0;
        srdata[d] <= 32'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (cs[d]) begin
          cs_cnt[d] <= cs_cnt[d] + 1;
          if (we[d]) begin
            we_cnt[d]     <= we_cnt[d] + 1;
            last_be[d]    <= be[d];
            last_waddr[d] <= saddr[d];
            for (int b = 0; b < 4; b++)
              if (be[d][b]) smem[d][saddr[d]][8*b +: 8] <= swdata[d][8*b +: 8];
          end else begin
            srdata[d] <= smem[d][saddr[d]];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic tx_t mk(input logic w, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] dt);
    tx_t t;
    t.write = w;
    t.addr  = a;
    t.size  = s;
    t.data  = dt;
    return t;
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int b;
    b = int'({a[13:2], 2'b00});
    return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
  endfunction

  // Reference write: size picks a span of bytes inside the word, misaligned spans align down.
  task automatic model_write(input int d, input tx_t t);
    int base, off, len;
    base = int'({t.addr[13:2], 2'b00});
    case (t.size)
      3'd0:    begin off = int'(t.addr[1:0]); len = 1; end
      3'd1:    begin off = t.addr[1] ? 2 : 0; len = 2; end
      default: begin off = 0; len = 4; end
    endcase
    for (int k = 0; k < len; k++) mdl[d][base + off + k] = t.data[8*(off+k) +: 8];
  endtask

  // Drives txq back-to-back on instance d, checking read data and overall timing.
  task automatic run_seq(input int d, input int ws, input string tag);
    int   n, idx, dp, cyc, low, clash, nwr, we0, cs0;
    logic rdy;
    n = txq.size(); idx = 0; dp = -1; cyc = 0; low = 0; clash = 0; nwr = 0;
    we0 = we_cnt[d]; cs0 = cs_cnt[d];
    for (int i = 0; i < n; i++) begin
      if (txq[i].write) nwr++;
      if (i > 0 && txq[i-1].write && !txq[i].write) clash++;
    end
    do begin
      if (idx < n) begin
        htrans[d] = 2'b10; haddr[d] = txq[idx].addr;
        hwrite[d] = txq[idx].write; hsize[d] = txq[idx].size;
      end else begin
        htrans[d] = 2'b00; haddr[d] = $urandom; hwrite[d] = 1'($urandom); hsize[d] = 3'b010;
      end
      hwdata[d] = (dp >= 0 && txq[dp].write) ? txq[dp].data : $urandom;
      @(negedge clk);
      cyc++;
      rdy = ready[d];
      if (!rdy) low++;
      if (dp >= 0 && !txq[dp].write) begin
        if (rdy) begin
          chk({tag, " rdata"}, rdata[d], model_word(d, txq[dp].addr));
          last_rdata = rdata[d];
        end
      end else begin
        chk({tag, " rdata_zero"}, rdata[d], 32'h0);
      end
      if (rdy && dp >= 0 && txq[dp].write) model_write(d, txq[dp]);
      @(posedge clk); #1;
      if (rdy) begin
        if (idx < n) begin dp = idx; idx++; end
        else dp = -1;
      end
    end while ((idx < n || dp >= 0) && cyc < 400);
    htrans[d] = 2'b00;
    chk({tag, " cycles"}, 32'(cyc), 32'(1 + n*(1+ws) + clash));
    chk({tag, " ready_low"}, 32'(low), 32'(n*ws + clash));
    chk({tag, " we_pulses"}, 32'(we_cnt[d] - we0), 32'(nwr));
    chk({tag, " cs_pulses"}, 32'(cs_cnt[d] - cs0), 32'(n));
    txq.delete();
  endtask

  task automatic rand_batch(input int d, input int ws, input int n);
    logic [2:0]  s;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      s = 3'($urandom_range(0, 2));
      a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 15) * 4);
      if (s == 3'd0) a = a | 32'($urandom_range(0, 3));
      if (s == 3'd1) a = a | 32'($urandom_range(0, 1) * 2);
      txq.push_back(mk(1'($urandom), a, s, $urandom));
    end
    run_seq(d, ws, (d == 0) ? "rand_ws0" : "rand_ws2");
  endtask

  initial begin
    logic [31:0] wv;
    reset = 1'b1;
    mem_clr = 1'b1;
    last_rdata = 32'h0;
    for (int d = 0; d < 2; d++) begin
      haddr[d] = 32'h0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
      hwdata[d] = 32'h0; hsize[d] = 3'b010;
      for (int b = 0; b < 16384; b++) mdl[d][b] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset ready", 32'(ready[d]), 32'h1);
      chk("reset rdata", rdata[d], 32'h0);
      chk("reset cs", 32'(cs[d]), 32'h0);
      chk("reset we", 32'(we[d]), 32'h0);
      chk("reset be", 32'(be[d]), 32'h0);
      chk("reset size_err", 32'(serr[d]), 32'h0);
    end
    @(posedge clk); #1 reset = 1'b0;

    // Idle/busy bus only.
    for (int c = 0; c < 20; c++) begin
      for (int d = 0; d < 2; d++) begin
        htrans[d] = 2'($urandom_range(0, 1)); haddr[d] = $urandom; hwrite[d] = 1'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("idle ready", 32'(ready[d]), 32'h1);
        chk("idle cs", 32'(cs[d]), 32'h0);
        chk("idle rdata", rdata[d], 32'h0);
      end
      @(posedge clk); #1;
    end
    htrans[0] = 2'b00; htrans[1] = 2'b00;

    // Write then read of the same word: one clash cycle.
    txq.push_back(mk(1'b1, 32'h100, 3'b010, 32'h1122_3344));
    txq.push_back(mk(1'b0, 32'h100, 3'b010, 32'h0));
    run_seq(0, 0, "wr_rd_clash");
    chk("wr_rd value", last_rdata, 32'h1122_3344);

    // Byte write into the top lane.
    txq.push_back(mk(1'b1, 32'h103, 3'b000, 32'hAA00_0000));
    run_seq(0, 0, "byte_wr");
    chk("byte_wr be", 32'(last_be[0]), 32'h8);
    chk("byte_wr addr", 32'(last_waddr[0]), 32'h40);
    txq.push_back(mk(1'b0, 32'h100, 3'b010, 32'h0));
    run_seq(0, 0, "byte_rd");
    chk("byte_rd value", last_rdata, 32'hAA22_3344);

    // Two wait states.
    wv = $urandom;
    txq.push_back(mk(1'b1, 32'h40, 3'b010, wv));
    run_seq(1, 2, "ws2_wr");
    txq.push_back(mk(1'b0, 32'h40, 3'b010, 32'h0));
    run_seq(1, 2, "ws2_rd");
    chk("ws2_rd value", last_rdata, wv);
    for (int i = 0; i < 4; i++) txq.push_back(mk(1'b0, 32'h40 + 32'(4*i), 3'b010, 32'h0));
    run_seq(1, 2, "ws2_b2b_rd");
    txq.push_back(mk(1'b1, 32'h44, 3'b001, $urandom));
    txq.push_back(mk(1'b0, 32'h44, 3'b010, 32'h0));
    run_seq(1, 2, "ws2_clash");

    for (int r = 0; r < 3; r++) begin
      rand_batch(0, 0, 12);
      rand_batch(1, 2, 12);
    end
    chk("size_err clean dev0", 32'(serr[0]), 32'h0);
    chk("size_err clean dev1", 32'(serr[1]), 32'h0);

    // Unsupported size and misaligned half.
    txq.push_back(mk(1'b1, 32'h200, 3'b011, $urandom));
    run_seq(0, 0, "size3_wr");
    chk("size3 be", 32'(last_be[0]), 32'hF);
    chk("size3 addr", 32'(last_waddr[0]), 32'h80);
    chk("size3 err", 32'(serr[0]), 32'h1);
    txq.push_back(mk(1'b1, 32'h201, 3'b001, $urandom));
    run_seq(0, 0, "half_mis_wr");
    chk("half_mis be", 32'(last_be[0]), 32'h3);
    chk("half_mis addr", 32'(last_waddr[0]), 32'h80);
    chk("half_mis err", 32'(serr[0]), 32'h1);
    txq.push_back(mk(1'b0, 32'h200, 3'b010, 32'h0));
    run_seq(0, 0, "size_rd");

    // Reset during the stall cycle after a write.
    wv = $urandom;
    htrans[0] = 2'b10; haddr[0] = 32'hAB0; hwrite[0] = 1'b1; hsize[0] = 3'b010;
    @(posedge clk); #1;
    htrans[0] = 2'b10; haddr[0] = 32'hAB0; hwrite[0] = 1'b0; hwdata[0] = wv;
    @(negedge clk);
    chk("stall clash ready", 32'(ready[0]), 32'h0);
    chk("stall clash we", 32'(we[0]), 32'h1);
    @(posedge clk); #1;
    model_write(0, mk(1'b1, 32'hAB0, 3'b010, wv));
    reset = 1'b1;
    #1;
    chk("rst_stall ready", 32'(ready[0]), 32'h1);
    chk("rst_stall cs", 32'(cs[0]), 32'h0);
    chk("rst_stall rdata", rdata[0], 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    htrans[0] = 2'b00;
    chk("rst_stall size_err", 32'(serr[0]), 32'h0);
    txq.push_back(mk(1'b0, 32'hAB0, 3'b010, 32'h0));
    run_seq(0, 0, "rst_stall_rd");
    chk("rst_stall value", last_rdata, wv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
